// File: rtl/riscv_mdu_seq.sv
// Multi-cycle RISC-V M-extension sequencer: radix-2 shift-add multiply and, when
// RISCV_MDU_DIV_EN is defined, restoring divide. Without the macro, divide ops
// return 0 on the fast path. The result is handed to writeback via valid/ready.
module riscv_mdu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rdi,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN);

`ifdef RISCV_MDU_DIV_EN
  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StMul, StFix, StDone} state_e;
`endif

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  // Mul: {hi = partial product, lo = multiplier}. Div: {hi = remainder, lo = dividend/quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mag_q, mag_d;   // multiplicand or divisor magnitude
  logic [2:0]          op_q, op_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic [4:0]          rdp_q, rdp_d;   // rd pending until the result is ready
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_q, rd_d;

  logic                accept, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                fast;
  logic [XLEN-1:0]     fast_res;
  logic [XLEN:0]       add_sum;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     fix_res;

  assign accept = in_valid && (state_q == StIdle) && !flush;

  // Operand signedness and magnitudes for the requested op
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (funct3)
      3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                 a_signed = 1'b1;
      default: ;
    endcase
    a_neg = a_signed && a[XLEN-1];
    b_neg = b_signed && b[XLEN-1];
    // Most-negative value maps to itself, which is its correct unsigned magnitude
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Divide corner cases that bypass the iterative datapath
  always_comb begin
    fast     = funct3[2];
    fast_res = '0;
`ifdef RISCV_MDU_DIV_EN
    if (b == '0) begin
      fast_res = funct3[1] ? a : '1;
    end else if (!funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
      fast_res = funct3[1] ? '0 : a;
    end else begin
      fast = 1'b0;
    end
    fast = fast && funct3[2];
`endif
  end

  assign add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);

`ifdef RISCV_MDU_DIV_EN
  logic [XLEN:0] trial, diff;
  logic          ge;
  assign trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff  = trial - {1'b0, mag_q};
  assign ge    = (trial >= {1'b0, mag_q});
`endif

  // Sign correction and output selection
  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    unique case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
`ifdef RISCV_MDU_DIV_EN
      3'b100, 3'b101: fix_res = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      3'b110, 3'b111: fix_res = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`endif
      default:                fix_res = '0;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    rdp_d    = rdp_q;
    result_d = result_q;
    rd_d     = rd_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = funct3;
          sa_d  = a_neg;
          sb_d  = b_neg;
          rdp_d = rdi;
          cnt_d = CntW'(XLEN - 1);
          if (!funct3[2]) begin
            acc_d   = {{XLEN{1'b0}}, b_mag};
            mag_d   = a_mag;
            state_d = StMul;
          end else if (fast) begin
            result_d = fast_res;
            rd_d     = rdi;
            state_d  = StDone;
          end else begin
`ifdef RISCV_MDU_DIV_EN
            acc_d   = {{XLEN{1'b0}}, a_mag};
            mag_d   = b_mag;
            state_d = StDiv;
`endif
          end
        end
      end
      StMul: begin
        acc_d = {add_sum, acc_q[XLEN-1:1]};
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d = cnt_q - CntW'(1);
      end
`ifdef RISCV_MDU_DIV_EN
      StDiv: begin
        acc_d = {(ge ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc_q[XLEN-2:0], ge};
        if (cnt_q == '0) state_d = StFix;
        else             cnt_d = cnt_q - CntW'(1);
      end
`endif
      StFix: begin
        result_d = fix_res;
        rd_d     = rdp_q;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort leaves the last delivered result and rd untouched
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
      rd_d     = rd_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      rdp_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      rdp_q    <= rdp_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign rd        = rd_q;

endmodule
